// File: rtl/alu_issue_scheduler_pkg.sv
// Shared types and configuration for the ALU issue scheduler slice.
package alu_issue_scheduler_pkg;

  localparam int ALU_UNIT_NUM   = 2;
  localparam int ALU_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  rd_phy;
    logic [5:0]  rob_id;
    logic        valid;
  } issue_execute_pack_t;

  typedef struct packed {
    logic       enable;
    logic       flush;
    logic [5:0] committed_rob_id;
    logic [1:0] committed_num;
  } commit_feedback_pack_t;

endpackage

// File: rtl/alu_issue_scheduler_credit_counter.sv
// Per-unit free-slot counter tracking space left in one issue_alu FIFO.
module alu_credit_counter #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [CW-1:0] o_count,
  output logic          o_nonzero
);

  logic [CW-1:0] r_count;

  // Push consumes a slot, pop returns one; flush or reset refills the FIFO budget.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_count <= CW'(DEPTH);
    end else begin
      r_count <= r_count - CW'(i_push) + CW'(i_pop);
    end
  end

  assign o_count   = r_count;
  assign o_nonzero = (r_count != '0);

  a_no_pop_when_full : assert property (@(posedge clk) disable iff (rst || i_flush)
    !(i_pop && !i_push && (r_count == CW'(DEPTH))));

  a_no_push_when_empty : assert property (@(posedge clk) disable iff (rst || i_flush)
    !(i_push && (r_count == '0)));

endmodule

// File: rtl/alu_issue_scheduler.sv
// One-entry holding register that dispatches issued ALU instructions
// round-robin to per-unit FIFOs under credit flow control.
module alu_issue_scheduler #(
  parameter int ALU_UNIT_NUM   = alu_issue_scheduler_pkg::ALU_UNIT_NUM,
  parameter int ALU_FIFO_DEPTH = alu_issue_scheduler_pkg::ALU_FIFO_DEPTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  alu_issue_scheduler_pkg::issue_execute_pack_t  issue_alu_pack_in,
  input  logic                                          issue_alu_valid,
  output logic                                          issue_alu_ready,
  output alu_issue_scheduler_pkg::issue_execute_pack_t  alu_fifo_data_in [ALU_UNIT_NUM],
  output logic [ALU_UNIT_NUM-1:0]                       alu_fifo_push,
  input  logic [ALU_UNIT_NUM-1:0]                       alu_fifo_pop,
  output logic                                          alu_fifo_flush,
  input  alu_issue_scheduler_pkg::commit_feedback_pack_t commit_feedback_pack,
  output logic                                          alu_sched_idle
);

  import alu_issue_scheduler_pkg::*;

  localparam int RRW = (ALU_UNIT_NUM > 1) ? $clog2(ALU_UNIT_NUM) : 1;
  localparam int CW  = $clog2(ALU_FIFO_DEPTH + 1);

  logic                    r_hold_valid;
  issue_execute_pack_t     r_hold_pack;
  logic [RRW-1:0]          r_rr_ptr;

  logic                    w_flush_now;
  logic                    w_found;
  logic [RRW-1:0]          w_sel;
  logic [RRW-1:0]          w_rr_next;
  logic                    w_fire;
  logic                    w_accept;
  logic [ALU_UNIT_NUM-1:0] w_push;
  logic [ALU_UNIT_NUM-1:0] w_nonzero;
  logic [ALU_UNIT_NUM-1:0] w_full;
  logic [CW-1:0]           w_count [ALU_UNIT_NUM];
  int unsigned             w_scan;
  logic                    w_unused_cfb;

  assign w_unused_cfb = ^{commit_feedback_pack.committed_rob_id, commit_feedback_pack.committed_num};

  assign w_flush_now = commit_feedback_pack.enable && commit_feedback_pack.flush;

  // Round-robin find-first unit with a free slot, starting at r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_scan  = 0;
    for (int unsigned k = 0; k < ALU_UNIT_NUM; k++) begin
      w_scan = (32'(r_rr_ptr) + k) % ALU_UNIT_NUM;
      if (!w_found && w_nonzero[w_scan[RRW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = RRW'(w_scan);
      end
    end
  end

  assign w_fire    = r_hold_valid && w_found && !w_flush_now && !rst;
  assign w_accept  = issue_alu_valid && issue_alu_ready;
  assign w_rr_next = (w_sel == RRW'(ALU_UNIT_NUM - 1)) ? '0 : w_sel + 1'b1;

  // One-hot push strobe towards the selected unit.
  always_comb begin
    w_push = '0;
    if (w_fire) begin
      w_push[w_sel] = 1'b1;
    end
  end

  // Holding register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_pack  <= '0;
      r_rr_ptr     <= '0;
    end else if (w_flush_now) begin
      r_hold_valid <= 1'b0;
      r_rr_ptr     <= '0;
    end else begin
      if (w_accept) begin
        r_hold_pack  <= issue_alu_pack_in;
        r_hold_valid <= 1'b1;
      end else if (w_fire) begin
        r_hold_valid <= 1'b0;
      end
      if (w_fire) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  for (genvar g = 0; g < ALU_UNIT_NUM; g++) begin : g_unit
    alu_credit_counter #(
      .DEPTH(ALU_FIFO_DEPTH),
      .CW   (CW)
    ) u_credit (
      .clk      (clk),
      .rst      (rst),
      .i_push   (w_push[g]),
      .i_pop    (alu_fifo_pop[g]),
      .i_flush  (w_flush_now),
      .o_count  (w_count[g]),
      .o_nonzero(w_nonzero[g])
    );
    assign w_full[g]           = (w_count[g] == CW'(ALU_FIFO_DEPTH));
    assign alu_fifo_data_in[g] = r_hold_pack;
  end

  assign issue_alu_ready = !rst && !w_flush_now && (!r_hold_valid || w_fire);
  assign alu_fifo_push   = w_push;
  assign alu_fifo_flush  = w_flush_now && !rst;
  assign alu_sched_idle  = !rst && !r_hold_valid && (&w_full);

  a_push_onehot : assert property (@(posedge clk) $onehot0(alu_fifo_push));

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Randomised and directed bench for alu_issue_scheduler against a FIFO-occupancy model.
module tb_alu_issue_scheduler;
  import alu_issue_scheduler_pkg::*;

  localparam int N = 2;
  localparam int D = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  issue_execute_pack_t   issue_alu_pack_in = '0;
  logic                  issue_alu_valid = 1'b0;
  logic                  issue_alu_ready;
  issue_execute_pack_t   alu_fifo_data_in [N];
  logic [N-1:0]          alu_fifo_push;
  logic [N-1:0]          alu_fifo_pop = '0;
  logic                  alu_fifo_flush;
  commit_feedback_pack_t commit_feedback_pack = '0;
  logic                  alu_sched_idle;

  alu_issue_scheduler #(
    .ALU_UNIT_NUM  (N),
    .ALU_FIFO_DEPTH(D)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .issue_alu_pack_in   (issue_alu_pack_in),
    .issue_alu_valid     (issue_alu_valid),
    .issue_alu_ready     (issue_alu_ready),
    .alu_fifo_data_in    (alu_fifo_data_in),
    .alu_fifo_push       (alu_fifo_push),
    .alu_fifo_pop        (alu_fifo_pop),
    .alu_fifo_flush      (alu_fifo_flush),
    .commit_feedback_pack(commit_feedback_pack),
    .alu_sched_idle      (alu_sched_idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: occupancy of each downstream FIFO, holding slot, next unit to try.
  int                  m_occ [N];
  issue_execute_pack_t m_hold [$];
  int                  m_rr = 0;
  logic                m_fire, m_ready, m_flush;
  int                  m_sel;

  logic                s_v;
  issue_execute_pack_t s_p;
  logic [N-1:0]        s_pop;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic issue_execute_pack_t mk(input logic [31:0] pc);
    issue_execute_pack_t p;
    p        = '0;
    p.pc     = pc;
    p.inst   = $urandom;
    p.rd_phy = 7'($urandom);
    p.rob_id = 6'($urandom);
    p.valid  = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_occ[i] = 0;
    m_hold.delete();
    m_rr = 0;
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst                         = 1'b1;
    issue_alu_valid             = 1'($urandom);
    issue_alu_pack_in           = mk($urandom);
    alu_fifo_pop                = '0;
    commit_feedback_pack.enable = 1'($urandom);
    commit_feedback_pack.flush  = 1'($urandom);
    #1;
    chk("rst_ready", 128'(issue_alu_ready), 128'(0));
    chk("rst_push", 128'(alu_fifo_push), 128'(0));
    chk("rst_flush", 128'(alu_fifo_flush), 128'(0));
    chk("rst_idle", 128'(alu_sched_idle), 128'(0));
    @(posedge clk);
    model_clear();
  endtask

  // Drive one cycle's inputs and compare all outputs against the model.
  task automatic step_begin(input logic v, input issue_execute_pack_t p, input logic [N-1:0] pop,
                            input logic en, input logic fl);
    logic found;
    logic all_empty;
    logic [N-1:0] exp_push;
    @(negedge clk);
    rst                         = 1'b0;
    issue_alu_valid             = v;
    issue_alu_pack_in           = p;
    alu_fifo_pop                = pop;
    commit_feedback_pack        = '0;
    commit_feedback_pack.enable = en;
    commit_feedback_pack.flush  = fl;
    commit_feedback_pack.committed_rob_id = 6'($urandom);
    s_v   = v;
    s_p   = p;
    s_pop = pop;
    #1;
    m_flush = en && fl;
    found   = 1'b0;
    m_sel   = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && m_occ[(m_rr + k) % N] < D) begin
        found = 1'b1;
        m_sel = (m_rr + k) % N;
      end
    end
    m_fire  = (m_hold.size() != 0) && found && !m_flush;
    m_ready = !m_flush && ((m_hold.size() == 0) || m_fire);
    all_empty = 1'b1;
    for (int i = 0; i < N; i++) if (m_occ[i] != 0) all_empty = 1'b0;
    exp_push = '0;
    if (m_fire) exp_push[m_sel] = 1'b1;
    chk("ready", 128'(issue_alu_ready), 128'(m_ready));
    chk("push", 128'(alu_fifo_push), 128'(exp_push));
    chk("fifo_flush", 128'(alu_fifo_flush), 128'(m_flush));
    chk("idle", 128'(alu_sched_idle), 128'((m_hold.size() == 0) && all_empty));
    if (m_fire) chk("push_data", 128'(alu_fifo_data_in[m_sel]), 128'(m_hold[0]));
  endtask

  task automatic step_end();
    @(posedge clk);
    if (m_flush) begin
      model_clear();
    end else begin
      for (int i = 0; i < N; i++) if (s_pop[i]) m_occ[i]--;
      if (m_fire) begin
        m_occ[m_sel]++;
        void'(m_hold.pop_front());
        m_rr = (m_sel + 1) % N;
      end
      if (s_v && m_ready) m_hold.push_back(s_p);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] stream_push [8];
    int k;
    logic [N-1:0] rpop;
    logic en, fl;

    stream_push = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    model_clear();

    // Reset, then idle with full credits.
    reset_cycle();
    reset_cycle();
    step_begin(1'b0, '0, '0, 1'b0, 1'b0);
    chk("idle_after_reset", 128'(alu_sched_idle), 128'(1));
    chk("ready_after_reset", 128'(issue_alu_ready), 128'(1));
    step_end();

    // Stream without pops: alternate units until both FIFOs are full.
    k = 0;
    for (int c = 0; c < 10; c++) begin
      step_begin(1'b1, mk(32'h1000 + 32'(4 * k)), '0, 1'b0, 1'b0);
      if (c >= 1 && c <= 8) chk("stream_push", 128'(alu_fifo_push), 128'(stream_push[c-1]));
      if (c == 9) chk("stream_stall_ready", 128'(issue_alu_ready), 128'(0));
      if (m_ready) k++;
      step_end();
    end
    step_begin(1'b0, '0, '0, 1'b0, 1'b0);
    chk("stall_ready", 128'(issue_alu_ready), 128'(0));
    chk("stall_push", 128'(alu_fifo_push), 128'(0));
    chk("stall_pc", 128'(alu_fifo_data_in[0].pc), 128'(32'h1020));
    step_end();

    // Credit return on unit 1 takes effect one cycle later.
    step_begin(1'b0, '0, 2'b10, 1'b0, 1'b0);
    chk("pop_cycle_push", 128'(alu_fifo_push), 128'(0));
    step_end();
    step_begin(1'b0, '0, '0, 1'b0, 1'b0);
    chk("return_push", 128'(alu_fifo_push), 128'(2'b10));
    chk("return_pc", 128'(alu_fifo_data_in[1].pc), 128'(32'h1020));
    step_end();
    step_begin(1'b0, '0, '0, 1'b0, 1'b0);
    chk("return_nocredit", 128'(alu_fifo_push), 128'(0));
    step_end();

    // Skew: unit 0 full, unit 1 with three free slots.
    for (int c = 0; c < 3; c++) begin
      step_begin(1'b0, '0, 2'b10, 1'b0, 1'b0);
      step_end();
    end
    for (int c = 0; c < 4; c++) begin
      step_begin(c < 3, mk(32'h2000 + 32'(4 * c)), '0, 1'b0, 1'b0);
      if (c >= 1) chk("skew_push", 128'(alu_fifo_push), 128'(2'b10));
      step_end();
    end

    // Flush with an instruction held and credits 2/3.
    step_begin(1'b0, '0, 2'b11, 1'b0, 1'b0); step_end();
    step_begin(1'b0, '0, 2'b11, 1'b0, 1'b0); step_end();
    step_begin(1'b0, '0, 2'b10, 1'b0, 1'b0); step_end();
    step_begin(1'b1, mk(32'h2800), '0, 1'b0, 1'b0); step_end();
    step_begin(1'b1, mk(32'h2804), 2'b11, 1'b1, 1'b1);
    chk("flush_out", 128'(alu_fifo_flush), 128'(1));
    chk("flush_push", 128'(alu_fifo_push), 128'(0));
    chk("flush_ready", 128'(issue_alu_ready), 128'(0));
    step_end();
    step_begin(1'b0, '0, '0, 1'b0, 1'b0);
    chk("flush_idle", 128'(alu_sched_idle), 128'(1));
    step_end();
    step_begin(1'b1, mk(32'h3000), '0, 1'b0, 1'b0); step_end();

    // Refill, then push and pop unit 0 together at credit 1.
    for (int s = 0; s < 7; s++) begin
      step_begin(s < 6, mk(32'h3004 + 32'(4 * s)), (s == 6) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      chk("refill_push", 128'(alu_fifo_push), 128'((s % 2 == 0) ? 2'b01 : 2'b10));
      step_end();
    end
    step_begin(1'b1, mk(32'h3100), '0, 1'b0, 1'b0);
    chk("pp_idle_push", 128'(alu_fifo_push), 128'(0));
    step_end();
    step_begin(1'b1, mk(32'h3104), '0, 1'b0, 1'b0);
    chk("pp_unit1", 128'(alu_fifo_push), 128'(2'b10));
    step_end();
    step_begin(1'b0, '0, '0, 1'b0, 1'b0);
    chk("pp_unit0_kept_credit", 128'(alu_fifo_push), 128'(2'b01));
    step_end();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) begin
        reset_cycle();
      end else begin
        rpop = '0;
        for (int i = 0; i < N; i++) if (m_occ[i] > 0 && $urandom_range(2) == 0) rpop[i] = 1'b1;
        en = ($urandom_range(9) == 0);
        fl = ($urandom_range(4) == 0) ? 1'b1 : ($urandom_range(50) == 0);
        step_begin($urandom_range(9) < 7, mk($urandom), rpop, en, fl);
        step_end();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
